// File: rtl/psx_info_pkg.sv
// Shared definitions for the savestate/rewind info overlay: message codes,
// controller state encoding and default geometry.
package psx_info_pkg;

  localparam int MSG_LEN_DEF  = 16;
  localparam int NUM_MSGS_DEF = 16;

  // Message codes as issued by the savestate UI
  localparam logic [7:0] MSG_HELP       = 8'd1;
  localparam logic [7:0] MSG_SLOT_FIRST = 8'd2;
  localparam logic [7:0] MSG_SLOT_LAST  = 8'd5;
  localparam logic [7:0] MSG_SAVE_FIRST = 8'd6;
  localparam logic [7:0] MSG_LOAD_FIRST = 8'd10;
  localparam logic [7:0] MSG_LOAD_LAST  = 8'd13;
  localparam logic [7:0] MSG_REWIND     = 8'd14;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_WRITE,
    ST_SHOW
  } info_state_t;

  // Code 0 is "no message"; anything past the ROM is dropped.
  function automatic logic code_valid(input logic [7:0] code, input int num_msgs);
    return (code != 8'd0) && (int'(code) < num_msgs);
  endfunction

endpackage

// File: rtl/psx_info_display_timer.sv
// Display timer: clearable up-counter that saturates at its MSB and flags
// the cycle on which the MSB is about to be reached.
module info_display_timer #(
  parameter int WIDTH = 26
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_inc;

  assign cnt_inc = cnt_q + WIDTH'(1);
  // Flag one count early so the owner leaves after exactly 2^(WIDTH-1) cycles.
  assign expire_o = en_i & ~clr_i & cnt_inc[WIDTH-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && !cnt_q[WIDTH-1]) begin
      cnt_q <= cnt_inc;
    end
  end

endmodule

// File: rtl/psx_info_display.sv
// Info-request consumer: copies a fixed-length message from the external ROM
// into the OSD line buffer, then shows the overlay for a fixed time.
module psx_info_display
  import psx_info_pkg::*;
#(
  parameter  int DISPLAY_TIME_BITS = 26,
  parameter  int MSG_LEN           = MSG_LEN_DEF,
  parameter  int NUM_MSGS          = NUM_MSGS_DEF,
  localparam int AW                = $clog2(NUM_MSGS*MSG_LEN),
  localparam int IW                = $clog2(MSG_LEN),
  localparam int CW                = $clog2(NUM_MSGS)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          psx_info_req,
  input  logic [7:0]    psx_info,
  output logic [AW-1:0] rom_addr,
  input  logic [7:0]    rom_data,
  output logic          txt_we,
  output logic [IW-1:0] txt_addr,
  output logic [7:0]    txt_data,
  output logic          overlay_en,
  output logic          busy
);

  info_state_t   state_q;
  logic [CW-1:0] cur_code_q;
  logic [CW-1:0] pend_code_q;
  logic          pend_vld_q;
  logic [IW-1:0] idx_q;
  logic [AW-1:0] rom_addr_q;
  logic          txt_we_q;
  logic [IW-1:0] txt_addr_q;
  logic          overlay_q;
  logic          busy_q;

  logic          req_ok;
  logic [CW-1:0] req_code;
  logic          last_char;
  logic [IW-1:0] idx_nxt;
  logic          start_vld;
  logic [CW-1:0] start_code;
  logic          tmr_clr;
  logic          tmr_en;
  logic          tmr_exp;

  assign req_ok    = psx_info_req && code_valid(psx_info, NUM_MSGS);
  assign req_code  = psx_info[CW-1:0];
  assign last_char = &idx_q;
  assign idx_nxt   = idx_q + IW'(1);

  // A new copy starts from IDLE, on a different code in SHOW, or at the end
  // of a copy when a request is waiting (a same-cycle request beats the
  // stored one, so the latest always wins).
  always_comb begin
    start_vld  = 1'b0;
    start_code = req_code;
    unique case (state_q)
      ST_IDLE:  start_vld = req_ok;
      ST_SHOW:  start_vld = req_ok && (req_code != cur_code_q);
      ST_WRITE: begin
        if (last_char) begin
          start_vld  = req_ok || pend_vld_q;
          start_code = req_ok ? req_code : pend_code_q;
        end
      end
      default:  start_vld = 1'b0;
    endcase
  end

  assign tmr_en  = (state_q == ST_SHOW);
  assign tmr_clr = (state_q == ST_WRITE && last_char && !req_ok && !pend_vld_q) ||
                   (state_q == ST_SHOW && req_ok && req_code == cur_code_q);

  info_display_timer #(
    .WIDTH (DISPLAY_TIME_BITS)
  ) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr_i    (tmr_clr),
    .en_i     (tmr_en),
    .expire_o (tmr_exp)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cur_code_q  <= '0;
      pend_code_q <= '0;
      pend_vld_q  <= 1'b0;
      idx_q       <= '0;
      rom_addr_q  <= '0;
      txt_we_q    <= 1'b0;
      txt_addr_q  <= '0;
      overlay_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      txt_we_q <= 1'b0;
      if (start_vld) begin
        state_q    <= ST_ADDR;
        cur_code_q <= start_code;
        idx_q      <= '0;
        rom_addr_q <= {start_code, {IW{1'b0}}};
        pend_vld_q <= 1'b0;
        overlay_q  <= 1'b0;
        busy_q     <= 1'b1;
      end else begin
        unique case (state_q)
          ST_ADDR: begin
            state_q    <= ST_WRITE;
            txt_we_q   <= 1'b1;
            txt_addr_q <= idx_q;
          end
          ST_WRITE: begin
            if (!last_char) begin
              state_q    <= ST_ADDR;
              idx_q      <= idx_nxt;
              rom_addr_q <= {cur_code_q, idx_nxt};
            end else begin
              state_q   <= ST_SHOW;
              busy_q    <= 1'b0;
              overlay_q <= 1'b1;
            end
          end
          ST_SHOW: begin
            if (tmr_exp) begin
              state_q   <= ST_IDLE;
              overlay_q <= 1'b0;
            end
          end
          default: ;
        endcase
      end
      // Requests arriving mid-copy wait in a single slot until it finishes.
      if (req_ok && (state_q == ST_ADDR || (state_q == ST_WRITE && !last_char))) begin
        pend_vld_q  <= 1'b1;
        pend_code_q <= req_code;
      end
    end
  end

  assign rom_addr   = rom_addr_q;
  assign txt_we     = txt_we_q;
  assign txt_addr   = txt_addr_q;
  // The ROM's output register supplies the character in the WRITE cycle.
  assign txt_data   = txt_we_q ? rom_data : 8'd0;
  assign overlay_en = overlay_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_psx_info_display.sv
// Directed bench for psx_info_display: transaction-level model checked every
// cycle, plus literal checkpoints at the key cycles of each scenario.
module tb_psx_info_display;

  localparam int DTB      = 6;
  localparam int MSG_LEN  = 16;
  localparam int NUM_MSGS = 16;
  localparam int SHOW_CYC = 2 ** (DTB - 1);

  logic       clk = 1'b0;
  logic       reset_n;
  logic       psx_info_req;
  logic [7:0] psx_info;
  logic [7:0] rom_addr;
  logic [7:0] rom_data;
  logic       txt_we;
  logic [3:0] txt_addr;
  logic [7:0] txt_data;
  logic       overlay_en;
  logic       busy;

  int n_vec = 0;
  int n_bad = 0;

  logic [7:0] rom_mem [256];

  psx_info_display #(
    .DISPLAY_TIME_BITS (DTB),
    .MSG_LEN           (MSG_LEN),
    .NUM_MSGS          (NUM_MSGS)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .psx_info_req (psx_info_req),
    .psx_info     (psx_info),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .txt_we       (txt_we),
    .txt_addr     (txt_addr),
    .txt_data     (txt_data),
    .overlay_en   (overlay_en),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  initial begin
    for (int c = 0; c < 16; c++)
      for (int i = 0; i < 16; i++)
        rom_mem[c*16 + i] = 8'(c*16 + i);
  end

  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: mode 0 idle, 1 copying (m_p = cycle within copy), 2 showing
  // (m_left = visible cycles remaining).
  int m_mode = 0;
  int m_p = 0;
  int m_cur = 0;
  int m_left = 0;
  int m_pend = 0;
  int m_pcode = 0;

  initial begin
    int c;
    bit v;
    forever begin
      @(posedge clk);
      c = int'(psx_info);
      v = psx_info_req && c >= 1 && c < NUM_MSGS;
      if (!reset_n) begin
        m_mode = 0;
        m_pend = 0;
      end else if (m_mode == 1) begin
        if (v) begin m_pend = 1; m_pcode = c; end
        if (m_p == 2*MSG_LEN - 1) begin
          if (m_pend != 0) begin
            m_cur = m_pcode; m_p = 0; m_pend = 0;
          end else begin
            m_mode = 2; m_left = SHOW_CYC;
          end
        end else begin
          m_p++;
        end
      end else if (m_mode == 2) begin
        if (v && c == m_cur) m_left = SHOW_CYC;
        else if (v) begin m_mode = 1; m_cur = c; m_p = 0; end
        else begin
          m_left--;
          if (m_left == 0) m_mode = 0;
        end
      end else if (v) begin
        m_mode = 1; m_cur = c; m_p = 0;
      end
    end
  end

  initial begin
    bit e_we;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        chk("rst_busy", busy, 0);
        chk("rst_overlay", overlay_en, 0);
        chk("rst_txt_we", txt_we, 0);
        chk("rst_txt_addr", txt_addr, 0);
        chk("rst_txt_data", txt_data, 0);
        chk("rst_rom_addr", rom_addr, 0);
      end else begin
        e_we = (m_mode == 1) && (m_p % 2 == 1);
        chk("busy", busy, m_mode == 1);
        chk("overlay_en", overlay_en, m_mode == 2);
        chk("txt_we", txt_we, e_we);
        chk("txt_data", txt_data, e_we ? m_cur*16 + m_p/2 : 0);
        if (m_mode == 1) chk("rom_addr", rom_addr, m_cur*MSG_LEN + m_p/2);
        if (e_we) chk("txt_addr", txt_addr, m_p/2);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [7:0] code);
    psx_info_req = 1'b1;
    psx_info     = code;
    tick();
    psx_info_req = 1'b0;
    psx_info     = 8'd0;
  endtask

  initial begin
    reset_n      = 1'b0;
    psx_info_req = 1'b0;
    psx_info     = 8'd0;
    repeat (2) @(negedge clk);
    #1 reset_n = 1'b1;
    tick();

    // Basic copy of code 3 and display window
    pulse(8'd3);
    tick();
    chk("t1_first_data", txt_data, 8'h30);
    chk("t1_first_addr", txt_addr, 0);
    repeat (30) tick();
    chk("t1_last_data", txt_data, 8'h3F);
    chk("t1_last_addr", txt_addr, 15);
    chk("t1_ov_c32", overlay_en, 0);
    tick();
    chk("t1_ov_c33", overlay_en, 1);
    repeat (31) tick();
    chk("t1_ov_c64", overlay_en, 1);
    tick();
    chk("t1_ov_c65", overlay_en, 0);

    // Invalid codes are ignored
    pulse(8'd0);
    pulse(8'd20);
    repeat (4) tick();
    chk("t2_busy", busy, 0);
    chk("t2_overlay", overlay_en, 0);

    // Same-code refresh during SHOW
    pulse(8'd3);
    repeat (32) tick();
    chk("t3_ov_on", overlay_en, 1);
    repeat (19) tick();
    pulse(8'd3);
    chk("t3_no_recopy", busy, 0);
    repeat (31) tick();
    chk("t3_ov_held", overlay_en, 1);
    tick();
    chk("t3_ov_off", overlay_en, 0);

    // Pending slot: latest request wins after the running copy
    pulse(8'd2);
    repeat (9) tick();
    pulse(8'd7);
    tick();
    pulse(8'd9);
    repeat (19) tick();
    chk("t4_code2_last", txt_data, 8'h2F);
    chk("t4_ov_low", overlay_en, 0);
    repeat (2) tick();
    chk("t4_code9_first", txt_data, 8'h90);
    chk("t4_busy", busy, 1);
    repeat (30) tick();
    chk("t4_code9_last", txt_data, 8'h9F);
    tick();
    chk("t4_ov_on", overlay_en, 1);
    repeat (33) tick();
    chk("t4_idle", overlay_en, 0);

    // Different code during SHOW recopies with the overlay off
    pulse(8'd4);
    repeat (34) tick();
    pulse(8'd6);
    chk("t5_ov_drop", overlay_en, 0);
    chk("t5_busy", busy, 1);
    tick();
    chk("t5_first", txt_data, 8'h60);
    repeat (30) tick();
    chk("t5_last", txt_data, 8'h6F);
    tick();
    chk("t5_ov_on", overlay_en, 1);
    repeat (33) tick();
    chk("t5_idle", overlay_en, 0);

    // Asynchronous reset in the middle of a copy
    pulse(8'd11);
    repeat (17) tick();
    chk("t6_we_idx8", txt_we, 1);
    chk("t6_addr_idx8", txt_addr, 8);
    chk("t6_data_idx8", txt_data, 8'hB8);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_async_busy", busy, 0);
    chk("t6_async_we", txt_we, 0);
    chk("t6_async_addr", txt_addr, 0);
    chk("t6_async_data", txt_data, 0);
    chk("t6_async_rom", rom_addr, 0);
    chk("t6_async_ov", overlay_en, 0);
    repeat (2) @(negedge clk);
    #1 reset_n = 1'b1;
    tick();
    pulse(8'd5);
    tick();
    chk("t6_post_addr", txt_addr, 0);
    chk("t6_post_data", txt_data, 8'h50);
    repeat (31) tick();
    chk("t6_post_ov", overlay_en, 1);
    repeat (34) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
